hub75_scan_reader: RTL and testbench

Read-side engine for the HUB75 row buffer. Once per displayed row pair it fetches 64-bit pixel words from the simple-dual-port line buffer's read port. It then shifts them out to the panel as binary-coded-modulation (BCM) bit planes, driving shift clock, latch, output enable and row address. It sits between the line-buffer SDP (already filled by the frame writer) and the panel connector pins.

---
 rtl/hub75_pkg.sv | 42 ++++
 rtl/hub75_scan_reader_if.sv | 11 +
 rtl/hub75_bcm_timer.sv | 41 ++++
 rtl/hub75_scan_reader.sv | 212 +++++++++++++++++++++
 tb/tb_hub75_scan_reader.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/hub75_pkg.sv
// Shared types and pixel-word layout for the HUB75 scan-out engine.
// Pixel word: [23:0] upper pixel, [47:24] lower pixel, each R[23:16] G[15:8] B[7:0].
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY,
    S_DEAD,
    S_DONE
  } state_t;

  localparam int PIX_BITS  = 8;
  localparam int UPPER_LSB = 0;
  localparam int LOWER_LSB = 24;
  localparam int R_OFS     = 16;
  localparam int G_OFS     = 8;
  localparam int B_OFS     = 0;

  // Position of each colour bit on the 6-bit panel data bus {r0,g0,b0,r1,g1,b1}
  localparam int RGB_R0 = 5;
  localparam int RGB_G0 = 4;
  localparam int RGB_B0 = 3;
  localparam int RGB_R1 = 2;
  localparam int RGB_G1 = 1;
  localparam int RGB_B1 = 0;

  function automatic logic [5:0] bcm_slice(input logic [63:0] word, input logic [2:0] bit_idx);
    logic [5:0] rgb;
    rgb         = '0;
    rgb[RGB_R0] = word[6'(UPPER_LSB + R_OFS + int'(bit_idx))];
    rgb[RGB_G0] = word[6'(UPPER_LSB + G_OFS + int'(bit_idx))];
    rgb[RGB_B0] = word[6'(UPPER_LSB + B_OFS + int'(bit_idx))];
    rgb[RGB_R1] = word[6'(LOWER_LSB + R_OFS + int'(bit_idx))];
    rgb[RGB_G1] = word[6'(LOWER_LSB + G_OFS + int'(bit_idx))];
    rgb[RGB_B1] = word[6'(LOWER_LSB + B_OFS + int'(bit_idx))];
    return rgb;
  endfunction

endpackage

// File: rtl/hub75_scan_reader_if.sv
// Read port of the simple-dual-port line buffer (1-cycle read latency).
// master = scan reader issuing addresses, slave = buffer returning data.
interface hub75_scan_reader_if;
  logic [7:0]  rd_adr;
  logic        rd_ce;
  logic        rd_oce;
  logic [63:0] rd_dout;

  modport master (output rd_adr, output rd_ce, output rd_oce, input rd_dout);
  modport slave  (input rd_adr, input rd_ce, input rd_oce, output rd_dout);
endinterface

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter timing BCM display windows (BASE_CYCLES << plane)
// and blanking windows (DEAD_CYCLES); expire is high in the last counted cycle.
module hub75_bcm_timer #(
  parameter int PLANES      = 8,
  parameter int BASE_CYCLES = 4,
  parameter int DEAD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dead_sel,
  input  logic [2:0] plane,
  output logic       expire
);

  localparam int DISP_MAX = BASE_CYCLES << (PLANES - 1);
  localparam int LEN_MAX  = (DEAD_CYCLES > DISP_MAX) ? DEAD_CYCLES : DISP_MAX;
  localparam int CNT_W    = $clog2(LEN_MAX) + 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = dead_sel ? CNT_W'(DEAD_CYCLES) : (CNT_W'(BASE_CYCLES) << plane);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hub75_scan_reader.sv
// HUB75 row-pair scan-out: fetches pixel words from the line buffer and emits BCM bit planes.
// Optional macro HUB75_DEAD_TIME_EN inserts DEAD_CYCLES of blanking after every display window.
module hub75_scan_reader
  import hub75_pkg::*;
#(
  parameter int COLS        = 64,
  parameter int PLANES      = 8,
  parameter int BASE_CYCLES = 4,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [4:0]                 row_sel,
  output logic                       busy,
  output logic                       done,
  hub75_scan_reader_if.master        sdp,
  output logic [5:0]                 hub_rgb,
  output logic                       hub_clk,
  output logic                       hub_lat,
  output logic                       hub_oe_n,
  output logic [4:0]                 hub_addr
);

  localparam logic [7:0] LAST_COL   = 8'(COLS - 1);
  localparam logic [2:0] LAST_PLANE = 3'(PLANES - 1);

  state_t      state_q, state_d;
  logic [2:0]  plane_q, plane_d;
  logic [7:0]  col_q, col_d;
  logic        phase_q, phase_d;
  logic [4:0]  row_q, row_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rd_adr_q, rd_adr_d;
  logic        rd_ce_q, rd_ce_d;
  logic [5:0]  hub_rgb_q, hub_rgb_d;
  logic        hub_clk_q, hub_clk_d;
  logic        hub_lat_q, hub_lat_d;
  logic        hub_oe_n_q, hub_oe_n_d;
  logic [4:0]  hub_addr_q, hub_addr_d;

  logic        tmr_load, tmr_dead, tmr_expire;
  logic [2:0]  bit_idx;

  hub75_bcm_timer #(
    .PLANES      (PLANES),
    .BASE_CYCLES (BASE_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .dead_sel (tmr_dead),
    .plane    (plane_q),
    .expire   (tmr_expire)
  );

  // Planes are MSB-aligned: with fewer than 8 planes the low colour bits are dropped
  assign bit_idx = 3'(PIX_BITS - PLANES + int'(plane_q));

  always_comb begin
    state_d   = state_q;
    plane_d   = plane_q;
    col_d     = col_q;
    phase_d   = phase_q;
    row_d     = row_q;
    hub_rgb_d = hub_rgb_q;
    tmr_load  = 1'b0;
    tmr_dead  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          row_d   = row_sel;
          plane_d = '0;
          col_d   = '0;
          state_d = S_PREFETCH;
        end
      end
      S_PREFETCH: begin
        col_d   = '0;
        phase_d = 1'b0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (!phase_q) begin
          hub_rgb_d = bcm_slice(sdp.rd_dout, bit_idx);
          phase_d   = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (col_q == LAST_COL) begin
            state_d = S_LATCH;
          end else begin
            col_d = col_q + 8'd1;
          end
        end
      end
      S_LATCH: begin
        tmr_load = 1'b1;
        state_d  = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (tmr_expire) begin
`ifdef HUB75_DEAD_TIME_EN
          tmr_load = 1'b1;
          tmr_dead = 1'b1;
          state_d  = S_DEAD;
`else
          if (plane_q == LAST_PLANE) begin
            state_d = S_DONE;
          end else begin
            plane_d = plane_q + 3'd1;
            state_d = S_PREFETCH;
          end
`endif
        end
      end
`ifdef HUB75_DEAD_TIME_EN
      S_DEAD: begin
        if (tmr_expire) begin
          if (plane_q == LAST_PLANE) begin
            state_d = S_DONE;
          end else begin
            plane_d = plane_q + 3'd1;
            state_d = S_PREFETCH;
          end
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Pin outputs are registered from the next state so each pin level lines up with its state cycle
  always_comb begin
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    hub_clk_d  = (state_d == S_SHIFT) && phase_d;
    hub_lat_d  = (state_d == S_LATCH);
    hub_oe_n_d = (state_d != S_DISPLAY);
    rd_ce_d    = 1'b0;
    rd_adr_d   = rd_adr_q;
    hub_addr_d = hub_addr_q;

    if (state_d == S_PREFETCH) begin
      rd_ce_d  = 1'b1;
      rd_adr_d = '0;
    end else if ((state_d == S_SHIFT) && phase_d && (col_d < LAST_COL)) begin
      rd_ce_d  = 1'b1;
      rd_adr_d = col_d + 8'd1;
    end

    if ((state_d == S_LATCH) && (plane_d == '0)) begin
      hub_addr_d = row_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      plane_q    <= '0;
      col_q      <= '0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_adr_q   <= '0;
      rd_ce_q    <= 1'b0;
      hub_rgb_q  <= '0;
      hub_clk_q  <= 1'b0;
      hub_lat_q  <= 1'b0;
      hub_oe_n_q <= 1'b1;
      hub_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      plane_q    <= plane_d;
      col_q      <= col_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_adr_q   <= rd_adr_d;
      rd_ce_q    <= rd_ce_d;
      hub_rgb_q  <= hub_rgb_d;
      hub_clk_q  <= hub_clk_d;
      hub_lat_q  <= hub_lat_d;
      hub_oe_n_q <= hub_oe_n_d;
      hub_addr_q <= hub_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    row_q <= row_d;
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sdp.rd_adr = rd_adr_q;
  assign sdp.rd_ce  = rd_ce_q;
  assign sdp.rd_oce = 1'b1;
  assign hub_rgb    = hub_rgb_q;
  assign hub_clk    = hub_clk_q;
  assign hub_lat    = hub_lat_q;
  assign hub_oe_n   = hub_oe_n_q;
  assign hub_addr   = hub_addr_q;

endmodule

// File: tb/tb_hub75_scan_reader.sv
// Randomized bench for hub75_scan_reader: line-buffer model plus a per-row expectation
// derived from the BCM scan rules (pixel bits, OE windows, read order, row-scan latency).
module tb_hub75_scan_reader;

  localparam int COLS        = 4;
  localparam int PLANES      = 2;
  localparam int BASE_CYCLES = 2;
  localparam int DEAD_CYCLES = 3;
`ifdef HUB75_DEAD_TIME_EN
  localparam int DEAD_EFF = DEAD_CYCLES;
`else
  localparam int DEAD_EFF = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] row_sel;
  logic       busy, done;
  logic [5:0] hub_rgb;
  logic       hub_clk, hub_lat, hub_oe_n;
  logic [4:0] hub_addr;

  hub75_scan_reader_if sdp();

  hub75_scan_reader #(
    .COLS        (COLS),
    .PLANES      (PLANES),
    .BASE_CYCLES (BASE_CYCLES),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .row_sel  (row_sel),
    .busy     (busy),
    .done     (done),
    .sdp      (sdp),
    .hub_rgb  (hub_rgb),
    .hub_clk  (hub_clk),
    .hub_lat  (hub_lat),
    .hub_oe_n (hub_oe_n),
    .hub_addr (hub_addr)
  );

  always #5 clk = ~clk;

  // Line buffer read port: registered output, one cycle after an enabled address
  logic [63:0] mem [256];
  always @(posedge clk) begin
    if (reset) sdp.rd_dout <= '0;
    else if (sdp.rd_ce) sdp.rd_dout <= mem[sdp.rd_adr];
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_rgb(input logic [63:0] w, input int p);
    int b;
    logic [7:0] ur, ug, ub, lr, lg, lb;
    b  = 8 - PLANES + p;
    ur = w[23:16]; ug = w[15:8];  ub = w[7:0];
    lr = w[47:40]; lg = w[39:32]; lb = w[31:24];
    return {ur[b], ug[b], ub[b], lr[b], lg[b], lb[b]};
  endfunction

  task automatic fill_rand();
    for (int c = 0; c < COLS; c++) mem[c] = {$urandom, $urandom};
  endtask

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_busy"},     64'(busy),       64'd0);
    chk({pfx, "_done"},     64'(done),       64'd0);
    chk({pfx, "_rd_adr"},   64'(sdp.rd_adr), 64'd0);
    chk({pfx, "_rd_ce"},    64'(sdp.rd_ce),  64'd0);
    chk({pfx, "_rd_oce"},   64'(sdp.rd_oce), 64'd1);
    chk({pfx, "_hub_rgb"},  64'(hub_rgb),    64'd0);
    chk({pfx, "_hub_clk"},  64'(hub_clk),    64'd0);
    chk({pfx, "_hub_lat"},  64'(hub_lat),    64'd0);
    chk({pfx, "_hub_oe_n"}, 64'(hub_oe_n),   64'd1);
    chk({pfx, "_hub_addr"}, 64'(hub_addr),   64'd0);
  endtask

  task automatic run_scan(input logic [4:0] row, input bit poke, input string nm);
    logic [5:0] rgb_q[$];
    logic [7:0] adr_q[$];
    int oe_runs[$];
    int gaps[$];
    int run, last_oe, done_at, viol, busy_bad, addr_bad, quiet_bad, exp_lat, n_exp;
    run = 0; last_oe = -1; done_at = -1; viol = 0; busy_bad = 0; addr_bad = 0; quiet_bad = 0;

    exp_lat = 1;
    for (int p = 0; p < PLANES; p++) exp_lat += 2 + 2 * COLS + (BASE_CYCLES << p) + DEAD_EFF;

    @(negedge clk);
    start = 1'b1; row_sel = row;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk);
      start   = poke && (n == 5);
      row_sel = (poke && (n == 5)) ? 5'd9 : 5'($urandom);
      if (hub_clk) rgb_q.push_back(hub_rgb);
      if (!hub_oe_n) begin
        run++;
        last_oe = n;
        if (hub_clk || hub_lat) viol++;
      end else if (run > 0) begin
        oe_runs.push_back(run);
        run = 0;
      end
      if (sdp.rd_ce) begin
        adr_q.push_back(sdp.rd_adr);
        if (sdp.rd_adr == 8'd0 && last_oe >= 0) gaps.push_back(n - last_oe - 1);
      end
      if (hub_lat && hub_addr !== row) addr_bad++;
      if (done) begin
        done_at = n;
        gaps.push_back(n - last_oe - 1);
        if (busy) busy_bad++;
        break;
      end else if (!busy) begin
        busy_bad++;
      end
    end
    start = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || busy) quiet_bad++;
    end

    if (done_at < 0) chk({nm, "_done_seen"}, 64'd0, 64'd1);
    else             chk({nm, "_done_latency"}, 64'(done_at), 64'(exp_lat));

    n_exp = PLANES * COLS;
    chk({nm, "_shift_count"}, 64'(rgb_q.size()), 64'(n_exp));
    for (int k = 0; k < n_exp && k < rgb_q.size(); k++)
      chk($sformatf("%s_rgb_p%0d_c%0d", nm, k / COLS, k % COLS),
          64'(rgb_q[k]), 64'(exp_rgb(mem[k % COLS], k / COLS)));

    chk({nm, "_rd_count"}, 64'(adr_q.size()), 64'(n_exp));
    for (int k = 0; k < n_exp && k < adr_q.size(); k++)
      chk($sformatf("%s_rd_adr_%0d", nm, k), 64'(adr_q[k]), 64'(k % COLS));

    chk({nm, "_oe_windows"}, 64'(oe_runs.size()), 64'(PLANES));
    for (int p = 0; p < PLANES && p < oe_runs.size(); p++)
      chk($sformatf("%s_oe_len_p%0d", nm, p), 64'(oe_runs[p]), 64'(BASE_CYCLES << p));

    chk({nm, "_blank_gaps"}, 64'(gaps.size()), 64'(PLANES));
    for (int p = 0; p < PLANES && p < gaps.size(); p++)
      chk($sformatf("%s_blank_p%0d", nm, p), 64'(gaps[p]), 64'(DEAD_EFF));

    chk({nm, "_oe_overlap"}, 64'(viol), 64'd0);
    chk({nm, "_busy_shape"}, 64'(busy_bad), 64'd0);
    chk({nm, "_latch_addr"}, 64'(addr_bad), 64'd0);
    chk({nm, "_quiet_after"}, 64'(quiet_bad), 64'd0);
    chk({nm, "_hub_addr"}, 64'(hub_addr), 64'(row));
  endtask

  task automatic reset_mid_display();
    bit seen;
    seen = 1'b0;
    fill_rand();
    @(negedge clk);
    start = 1'b1; row_sel = 5'(1 + $urandom_range(0, 30));
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      if (!hub_oe_n) seen = 1'b1;
      else @(negedge clk);
    end
    chk("mid_reset_reach_display", 64'(seen), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_vals("mid_reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; row_sel = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    reset = 1'b0;

    for (int c = 0; c < COLS; c++) mem[c] = {16'h0000, 24'h40C080, 24'hC08040};
    run_scan(5'd5, 1'b1, "basic");

    for (int i = 0; i < 4; i++) begin
      fill_rand();
      run_scan(5'($urandom_range(0, 31)), 1'b0, $sformatf("rand%0d", i));
    end

    fill_rand();
    run_scan(5'd31, 1'b1, "busy_drop");

    reset_mid_display();
    fill_rand();
    run_scan(5'd17, 1'b0, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
